// File: rtl/ahb_lite_arbiter_2to1_if.sv
// Bus bundle for the 2:1 AHB-Lite arbiter: packed per-master signals (master i in slice i)
// plus the single downstream slave port. The arbiter uses "slave" (it is the masters' slave).
interface ahb_lite_arbiter_2to1_if #(
  parameter int XLen = 32
);
  logic [3:0]        m_htrans;
  logic [2*XLen-1:0] m_haddr;
  logic [1:0]        m_hwrite;
  logic [5:0]        m_hsize;
  logic [2*XLen-1:0] m_hwdata;
  logic [XLen-1:0]   m_hrdata;
  logic [1:0]        m_hready;
  logic [1:0]        m_hresp;

  logic [1:0]        s_htrans;
  logic [XLen-1:0]   s_haddr;
  logic              s_hwrite;
  logic [2:0]        s_hsize;
  logic [XLen-1:0]   s_hwdata;
  logic [XLen-1:0]   s_hrdata;
  logic              s_hready;
  logic              s_hresp;

  modport slave (
    input  m_htrans, m_haddr, m_hwrite, m_hsize, m_hwdata,
    input  s_hrdata, s_hready, s_hresp,
    output m_hrdata, m_hready, m_hresp,
    output s_htrans, s_haddr, s_hwrite, s_hsize, s_hwdata
  );

  modport master (
    output m_htrans, m_haddr, m_hwrite, m_hsize, m_hwdata,
    output s_hrdata, s_hready, s_hresp,
    input  m_hrdata, m_hready, m_hresp,
    input  s_htrans, s_haddr, s_hwrite, s_hsize, s_hwdata
  );
endinterface

// File: rtl/ahb_lite_arbiter_2to1.sv
// Two-master (0=imem, 1=dmem) to one-slave AHB-Lite arbiter with zero added latency.
// Define ARB_ROUND_ROBIN_EN to alternate on contention instead of fixed DMEM_PRIO priority.
module ahb_lite_arbiter_2to1 #(
  parameter int XLen      = 32,
  parameter bit DMEM_PRIO = 1'b1
) (
  input logic                   clock,
  input logic                   reset,
  ahb_lite_arbiter_2to1_if.slave bus
);
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  if (XLen != 32 && XLen != 64) begin : g_bad_xlen
    $fatal(1, "ahb_lite_arbiter_2to1: XLen must be 32 or 64");
  end

  logic [1:0]      htrans_arr [2];
  logic [XLen-1:0] haddr_arr  [2];
  logic            hwrite_arr [2];
  logic [2:0]      hsize_arr  [2];
  logic [XLen-1:0] hwdata_arr [2];
  logic [1:0]      req;
  logic [1:0]      hready_out;
  logic [1:0]      hresp_out;

  logic            dp_valid_reg;
  logic            dp_owner_reg;
  logic [XLen-1:0] haddr_hold_reg;

  logic            grant_valid;
  logic            grant;
  logic            contention_pick;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_reg;
  assign contention_pick = ~last_grant_reg;
`else
  assign contention_pick = DMEM_PRIO;
`endif

  // NONSEQ (10) and SEQ (11) both have bit 1 set; BUSY (01) counts as idle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic own_stall;
    logic addr_blocked;

    assign htrans_arr[gi] = bus.m_htrans[gi*2 +: 2];
    assign haddr_arr[gi]  = bus.m_haddr[gi*XLen +: XLen];
    assign hwrite_arr[gi] = bus.m_hwrite[gi];
    assign hsize_arr[gi]  = bus.m_hsize[gi*3 +: 3];
    assign hwdata_arr[gi] = bus.m_hwdata[gi*XLen +: XLen];
    assign req[gi]        = htrans_arr[gi][1];

    assign own_stall    = dp_valid_reg && (dp_owner_reg == 1'(gi)) && !bus.s_hready;
    assign addr_blocked = req[gi] && !(grant_valid && (grant == 1'(gi)));
    assign hready_out[gi] = reset || !(own_stall || addr_blocked);
    assign hresp_out[gi]  = !reset && dp_valid_reg && (dp_owner_reg == 1'(gi)) && bus.s_hresp;
  end

  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (!reset && bus.s_hready && (req != 2'b00)) begin
      grant_valid = 1'b1;
      grant       = (req == 2'b11) ? contention_pick : req[1];
    end
  end

  assign bus.s_htrans = grant_valid ? htrans_arr[grant] : HTRANS_IDLE;
  assign bus.s_haddr  = grant_valid ? haddr_arr[grant]  : haddr_hold_reg;
  assign bus.s_hwrite = grant_valid && hwrite_arr[grant];
  assign bus.s_hsize  = grant_valid ? hsize_arr[grant]  : 3'b000;
  assign bus.s_hwdata = (!reset && dp_valid_reg) ? hwdata_arr[dp_owner_reg] : '0;
  assign bus.m_hrdata = bus.s_hrdata;
  assign bus.m_hready = hready_out;
  assign bus.m_hresp  = hresp_out;

  // The held address survives reset so s_haddr never glitches while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      dp_valid_reg <= 1'b0;
      dp_owner_reg <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_reg <= 1'b0;
`endif
    end else if (bus.s_hready) begin
      dp_valid_reg <= grant_valid;
      if (grant_valid) begin
        dp_owner_reg   <= grant;
        haddr_hold_reg <= haddr_arr[grant];
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_reg <= grant;
`endif
      end
    end
  end
endmodule

// File: tb/tb_ahb_lite_arbiter_2to1.sv
// Self-checking bench for ahb_lite_arbiter_2to1: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model of the arbitration rules.
module tb_ahb_lite_arbiter_2to1;
  localparam int DMEM_PRIO = 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ahb_lite_arbiter_2to1_if #(.XLen(32)) bus ();

  ahb_lite_arbiter_2to1 #(.XLen(32), .DMEM_PRIO(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model: owner of the outstanding data phase (0 or 1 entries) and grant history.
  int          dp_q[$];
  int          gnt_hist[$];
  logic [31:0] last_addr;
  bit          addr_known = 1'b0;
  bit          stalled[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] req);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
`ifdef ARB_ROUND_ROBIN_EN
    if (gnt_hist.size() == 0) return 1;
    return 1 - gnt_hist[$];
`else
    return DMEM_PRIO;
`endif
  endfunction

  task automatic set_m(input int i, input logic [1:0] t, input logic [31:0] a,
                       input logic w, input logic [2:0] sz, input logic [31:0] d);
    bus.m_htrans[2*i +: 2] = t;
    bus.m_haddr[32*i +: 32] = a;
    bus.m_hwrite[i]         = w;
    bus.m_hsize[3*i +: 3]   = sz;
    bus.m_hwdata[32*i +: 32] = d;
  endtask

  task automatic step();
    logic [1:0]  req;
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_resp;
    logic [31:0] exp_wd;
    bit          gv;
    bit          dv;
    int          w;
    int          owner;
    @(negedge clock);
    for (int i = 0; i < 2; i++) req[i] = bus.m_htrans[2*i+1];
    dv    = (dp_q.size() != 0);
    owner = dv ? dp_q[0] : 0;
    gv    = !reset && bus.s_hready && (req != 2'b00);
    w     = gv ? pick(req) : 0;

    if (gv) begin
      check("s_htrans", 64'(bus.s_htrans), 64'(bus.m_htrans[2*w +: 2]));
      check("s_haddr", 64'(bus.s_haddr), 64'(bus.m_haddr[32*w +: 32]));
      check("s_hwrite", 64'(bus.s_hwrite), 64'(bus.m_hwrite[w]));
      check("s_hsize", 64'(bus.s_hsize), 64'(bus.m_hsize[3*w +: 3]));
    end else begin
      check("s_htrans_idle", 64'(bus.s_htrans), 64'(2'b00));
      if (addr_known) check("s_haddr_hold", 64'(bus.s_haddr), 64'(last_addr));
    end

    if (reset) begin
      exp_rdy  = 2'b11;
      exp_resp = 2'b00;
      exp_wd   = 32'h0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_rdy[i]  = !((dv && owner == i && !bus.s_hready) || (req[i] && !(gv && w == i)));
        exp_resp[i] = (dv && owner == i) ? bus.s_hresp : 1'b0;
      end
      exp_wd = dv ? bus.m_hwdata[32*owner +: 32] : 32'h0;
    end
    check("m_hready", 64'(bus.m_hready), 64'(exp_rdy));
    check("m_hresp", 64'(bus.m_hresp), 64'(exp_resp));
    check("s_hwdata", 64'(bus.s_hwdata), 64'(exp_wd));
    check("m_hrdata", 64'(bus.m_hrdata), 64'(bus.s_hrdata));

    $display("cyc %0d rst=%0b req=%b hrdy_s=%0b grant=%s dp=%s hready=%b hresp=%b",
             cyc, reset, req, bus.s_hready, gv ? $sformatf("%0d", w) : "-",
             dv ? $sformatf("%0d", owner) : "-", bus.m_hready, bus.m_hresp);

    for (int i = 0; i < 2; i++) stalled[i] = req[i] && !exp_rdy[i];
    if (reset) begin
      dp_q.delete();
      gnt_hist.delete();
    end else if (bus.s_hready) begin
      dp_q.delete();
      if (gv) begin
        dp_q.push_back(w);
        gnt_hist.push_back(w);
        last_addr  = bus.m_haddr[32*w +: 32];
        addr_known = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    reset        = 1'b1;
    bus.s_hready = 1'b1;
    bus.s_hresp  = 1'b0;
    bus.s_hrdata = 32'h0;
    set_m(0, 2'b10, 32'h0000_0040, 1'b0, 3'd2, 32'h0);
    set_m(1, 2'b10, 32'h0000_0080, 1'b1, 3'd2, 32'h1111_1111);
    @(posedge clock);
    #1;

    // Reset held with both masters requesting.
    repeat (3) step();
    reset = 1'b0;

    // imem alone reads 0x100; slave returns 0xDEADBEEF in the data phase.
    set_m(0, 2'b10, 32'h0000_0100, 1'b0, 3'd2, 32'h0);
    set_m(1, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0);
    step();
    set_m(0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0);
    bus.s_hrdata = 32'hDEAD_BEEF;
    step();

    // Contention: dmem writes 0x1000_0000, imem reads 0x4.
    set_m(0, 2'b10, 32'h0000_0004, 1'b0, 3'd2, 32'h0);
    set_m(1, 2'b10, 32'h1000_0000, 1'b1, 3'd2, 32'h0);
    step();
    set_m(1, 2'b00, 32'h0, 1'b0, 3'd2, 32'hCAFE_F00D);
    step();
    set_m(0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0);
    step();

    // dmem read with two slave wait states.
    set_m(1, 2'b10, 32'h0000_2000, 1'b0, 3'd2, 32'h0);
    step();
    set_m(1, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0);
    set_m(0, 2'b10, 32'h0000_0008, 1'b0, 3'd2, 32'h0);
    bus.s_hready = 1'b0;
    step();
    step();
    bus.s_hready = 1'b1;
    step();

    // imem data phase gets an error response.
    set_m(0, 2'b10, 32'h0000_000C, 1'b0, 3'd2, 32'h0);
    step();
    set_m(0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0);
    bus.s_hresp = 1'b1;
    step();
    bus.s_hresp = 1'b0;

    // Reset mid-transfer, then both masters request continuously.
    set_m(1, 2'b10, 32'h0000_3000, 1'b0, 3'd2, 32'h0);
    step();
    reset = 1'b1;
    set_m(1, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0);
    step();
    reset = 1'b0;
    set_m(0, 2'b10, 32'h0000_0010, 1'b0, 3'd2, 32'h0);
    set_m(1, 2'b10, 32'h0000_4000, 1'b0, 3'd2, 32'h0);
    repeat (4) step();

    // Random traffic; stalled masters hold their address phase.
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 99) < 3);
      bus.s_hready = ($urandom_range(0, 3) != 0);
      bus.s_hresp  = ($urandom_range(0, 9) == 0);
      bus.s_hrdata = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (!stalled[i])
          set_m(i, 2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)), $urandom);
        else
          bus.m_hwdata[32*i +: 32] = $urandom;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ahb_lite_arbiter_2to1.md
Name: ahb_lite_arbiter_2to1

Overview:
- Two-master to one-slave AHB-Lite arbiter placed between the core's imem/dmem ports and a single-ported memory/MMIO slave. Used when the testbench memory model is collapsed to one port.
- Tracks which master owns the current data phase, steers write data and responses to that master, and stalls the losing master via its hready.
- Master index 0 = imem, 1 = dmem.
- All per-master signals are packed, with master i in slice i.

Parameters:
- XLen, 32: address and data width; only 32 and 64 are legal.
- DMEM_PRIO, 1: the master that wins fixed-priority arbitration when both request (0 or 1).

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- m_htrans  in  2*2  per-master HTRANS
- m_haddr  in  2*XLen  per-master HADDR
- m_hwrite  in  2  per-master HWRITE
- m_hsize  in  2*3  per-master HSIZE
- m_hwdata  in  2*XLen  per-master HWDATA, valid in that master's data phase
- m_hrdata  out  XLen  shared read data, equal to s_hrdata
- m_hready  out  2  per-master HREADY
- m_hresp  out  2  per-master HRESP
- s_htrans  out  2  slave HTRANS
- s_haddr  out  XLen  slave HADDR
- s_hwrite  out  1  slave HWRITE
- s_hsize  out  3  slave HSIZE
- s_hwdata  out  XLen  slave HWDATA
- s_hrdata  in  XLen  slave read data
- s_hready  in  1  slave HREADY
- s_hresp  in  1  slave HRESP

Behaviour:
- Interface (already decided): one clock, named clock; reset is synchronous and active-high, named reset.
- Request: master i requests when m_htrans[i] is NONSEQ (2'b10) or SEQ (2'b11). BUSY is treated as IDLE.
- Grant: combinational, evaluated only while s_hready=1.
  - One requester: it is granted.
  - Two requesters: DMEM_PRIO wins (or the round-robin choice when enabled).
  - Granted master's haddr/hwrite/hsize/htrans drive the s_* address outputs.
  - No grant, or s_hready=0: s_htrans=IDLE and s_haddr holds its last value.
- Data-phase state: registers dp_valid (1 bit) and dp_owner (1 bit). When s_hready=1:
  - a grant sets dp_valid=1 and dp_owner=grant;
  - no grant sets dp_valid=0.
  - While s_hready=0, both registers hold.
- Write data: s_hwdata = m_hwdata[dp_owner] when dp_valid, else 0.
- m_hready[i] is 0 when either holds:
  - dp_valid, dp_owner==i and s_hready=0 (own data phase stalled), or
  - master i requests and is not granted this cycle (address held). This includes the case where all grants are blocked by s_hready=0.
  - Otherwise m_hready[i]=1.
- m_hresp[i] = s_hresp when dp_valid and dp_owner==i, else 0.
- Zero added latency: the address phase passes through combinationally; the data phase completes in the same cycle as on the slave.
- Back-to-back: the same master may hold the bus every cycle. A loser is re-arbitrated each cycle with its address held stable.
- Reset (synchronous, including mid-transfer):
  - dp_valid=0, dp_owner=0, s_htrans=IDLE;
  - m_hready=2'b11, m_hresp=0, s_hwdata=0;
  - any in-flight data phase is dropped.
- An illegal XLen causes elaboration to stop.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - adds a 1-bit last_grant register, reset to 0;
  - on a simultaneous request the master != last_grant wins;
  - last_grant updates on every grant taken with s_hready=1.
- Undefined: fixed priority per DMEM_PRIO and no extra register.

Test Plan:
- Reset with m_htrans=2'b10 on both masters → s_htrans=0, m_hready=2'b11, m_hresp=0 for every reset cycle.
- imem alone reads 0x100 and the slave returns 0xDEADBEEF → s_haddr=0x100 in the same cycle; next cycle m_hrdata=0xDEADBEEF with m_hready[0]=1.
- Both request in the same cycle: dmem writes 0x1000_0000, imem reads 0x4 (fixed priority) →
  - dmem granted first and m_hready[0]=0;
  - imem granted the following cycle;
  - s_hwdata = dmem data during dmem's data phase.
- Slave inserts 2 wait states (s_hready=0) on a dmem read → m_hready[1]=0 for 2 cycles, no new grant issued, s_htrans=IDLE, dp_owner stays 1.
- Slave asserts s_hresp=1 on an imem data phase → m_hresp=2'b01.
- ARB_ROUND_ROBIN_EN defined, both masters requesting continuously for 4 cycles → grant sequence 1,0,1,0, since dmem (master 1) wins first with last_grant reset to 0.
